// File: rtl/gcn_stage_scheduler.sv
// -----------------------------------------------------------------------------
// gcn_stage_scheduler
//
// Top-level sequencer for the GCN inference pipeline. A run launches the
// transformation stage (FM x WM), then the combination stage (ADJ x FM_WM),
// then the argmax stage, and finally captures the per-node class vector.
// Each busy stage is guarded by a watchdog, and the number of busy cycles of
// the current/last run is reported. The scheduler also arbitrates the
// ADJ_FM_WM memory read-row port between the argmax stage and host readback.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   start               run request (sampled in IDLE only)
//   clear_err           leave ERROR (sampled in ERROR only)
//   start_trans         one-cycle launch pulse, transformation stage
//   done_trans          transformation complete
//   start_comb          one-cycle launch pulse, combination stage
//   done_comb_in        combination complete
//   arg_go              level drive to the argmax stage, high in ARGMAX
//   done_arg            argmax complete
//   max_addi_ans        argmax result array
//   argmax_read_row     argmax row request to the memory
//   host_rd_req         host readback request
//   host_read_row       host row address
//   host_rd_gnt         host owns the memory read port this cycle
//   mem_read_row        row address driven to the ADJ_FM_WM memory
//   result              captured argmax vector
//   result_valid        result holds a completed run
//   busy                state is TRANS, COMB or ARGMAX
//   error               watchdog fired
//   err_stage           stage that timed out (1 TRANS, 2 COMB, 3 ARGMAX)
//   run_cycles          busy cycles of the last/current run, saturating
// -----------------------------------------------------------------------------
module gcn_stage_scheduler #(
    parameter int ARGMAX_ROWS     = 6,
    parameter int ARGMAX_COLS     = 2,
    parameter int FEATURE_WIDTH   = $clog2(ARGMAX_ROWS),
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int TIMEOUT_WIDTH   = $clog2(TIMEOUT_CYCLES),
    parameter int CYCLE_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       clear_err,
    output logic                       start_trans,
    input  logic                       done_trans,
    output logic                       start_comb,
    input  logic                       done_comb_in,
    output logic                       arg_go,
    input  logic                       done_arg,
    input  logic [ARGMAX_COLS-1:0]     max_addi_ans [0:ARGMAX_ROWS-1],
    input  logic [FEATURE_WIDTH-1:0]   argmax_read_row,
    input  logic                       host_rd_req,
    input  logic [FEATURE_WIDTH-1:0]   host_read_row,
    output logic                       host_rd_gnt,
    output logic [FEATURE_WIDTH-1:0]   mem_read_row,
    output logic [ARGMAX_COLS-1:0]     result [0:ARGMAX_ROWS-1],
    output logic                       result_valid,
    output logic                       busy,
    output logic                       error,
    output logic [1:0]                 err_stage,
    output logic [CYCLE_CNT_WIDTH-1:0] run_cycles
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRANS,
        ST_COMB,
        ST_ARGMAX,
        ST_ERROR
    } state_t;

    localparam logic [1:0] STAGE_TRANS  = 2'd1;
    localparam logic [1:0] STAGE_COMB   = 2'd2;
    localparam logic [1:0] STAGE_ARGMAX = 2'd3;

    state_t                     r_state;
    logic                       r_start_trans;
    logic                       r_start_comb;
    logic                       r_arg_go;
    logic                       r_busy;
    logic                       r_error;
    logic [1:0]                 r_err_stage;
    logic                       r_result_valid;
    logic [ARGMAX_COLS-1:0]     r_result [0:ARGMAX_ROWS-1];
    logic [TIMEOUT_WIDTH-1:0]   r_wdog;
    logic [CYCLE_CNT_WIDTH-1:0] r_run_cycles;

    logic w_wdog_expired;
    logic w_in_run;

    // The watchdog only matters when the stage's done input is low; done wins.
    assign w_wdog_expired = (r_wdog == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign w_in_run       = (r_state == ST_TRANS) || (r_state == ST_COMB) ||
                            (r_state == ST_ARGMAX);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_start_trans  <= 1'b0;
            r_start_comb   <= 1'b0;
            r_arg_go       <= 1'b0;
            r_busy         <= 1'b0;
            r_error        <= 1'b0;
            r_err_stage    <= 2'd0;
            r_result_valid <= 1'b0;
            r_wdog         <= '0;
            r_run_cycles   <= '0;
            // NOTE: the result array is reset explicitly because it is a
            // visible output with a defined reset value, not scratch storage.
            for (int i = 0; i < ARGMAX_ROWS; i++) begin
                r_result[i] <= '0;
            end
        end else begin
            // Launch pulses last exactly one cycle unless re-armed below.
            r_start_trans <= 1'b0;
            r_start_comb  <= 1'b0;

            if (w_in_run && (r_run_cycles != '1)) begin
                r_run_cycles <= r_run_cycles + CYCLE_CNT_WIDTH'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state        <= ST_TRANS;
                        r_start_trans  <= 1'b1;
                        r_busy         <= 1'b1;
                        r_result_valid <= 1'b0;
                        r_run_cycles   <= '0;
                        r_wdog         <= '0;
                    end
                end

                ST_TRANS: begin
                    if (done_trans) begin
                        r_state      <= ST_COMB;
                        r_start_comb <= 1'b1;
                        r_wdog       <= '0;
                    end else if (w_wdog_expired) begin
                        r_state     <= ST_ERROR;
                        r_busy      <= 1'b0;
                        r_error     <= 1'b1;
                        r_err_stage <= STAGE_TRANS;
                    end else begin
                        r_wdog <= r_wdog + TIMEOUT_WIDTH'(1);
                    end
                end

                ST_COMB: begin
                    if (done_comb_in) begin
                        r_state  <= ST_ARGMAX;
                        r_arg_go <= 1'b1;
                        r_wdog   <= '0;
                    end else if (w_wdog_expired) begin
                        r_state     <= ST_ERROR;
                        r_busy      <= 1'b0;
                        r_error     <= 1'b1;
                        r_err_stage <= STAGE_COMB;
                    end else begin
                        r_wdog <= r_wdog + TIMEOUT_WIDTH'(1);
                    end
                end

                ST_ARGMAX: begin
                    if (done_arg) begin
                        r_state        <= ST_IDLE;
                        r_arg_go       <= 1'b0;
                        r_busy         <= 1'b0;
                        r_result       <= max_addi_ans;
                        r_result_valid <= 1'b1;
                    end else if (w_wdog_expired) begin
                        r_state     <= ST_ERROR;
                        r_arg_go    <= 1'b0;
                        r_busy      <= 1'b0;
                        r_error     <= 1'b1;
                        r_err_stage <= STAGE_ARGMAX;
                    end else begin
                        r_wdog <= r_wdog + TIMEOUT_WIDTH'(1);
                    end
                end

                ST_ERROR: begin
                    // start is deliberately not looked at here.
                    if (clear_err) begin
                        r_state     <= ST_IDLE;
                        r_error     <= 1'b0;
                        r_err_stage <= 2'd0;
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_arg_go <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    // Memory read-port arbitration, decoded straight from the state register:
    // the argmax stage owns the port in ARGMAX, the host owns it while idle or
    // halted, and nobody reads during TRANS/COMB.
    // NOTE: both outputs get a default before the case so no path leaves them
    // unassigned, which would otherwise infer latches.
    always_comb begin
        mem_read_row = '0;
        host_rd_gnt  = 1'b0;
        case (r_state)
            ST_ARGMAX: begin
                mem_read_row = argmax_read_row;
            end
            ST_IDLE, ST_ERROR: begin
                mem_read_row = host_read_row;
                host_rd_gnt  = host_rd_req;
            end
            default: begin
                mem_read_row = '0;
                host_rd_gnt  = 1'b0;
            end
        endcase
    end

    assign start_trans  = r_start_trans;
    assign start_comb   = r_start_comb;
    assign arg_go       = r_arg_go;
    assign busy         = r_busy;
    assign error        = r_error;
    assign err_stage    = r_err_stage;
    assign result_valid = r_result_valid;
    assign result       = r_result;
    assign run_cycles   = r_run_cycles;

endmodule

// File: tb/tb_gcn_stage_scheduler.sv
// -----------------------------------------------------------------------------
// tb_gcn_stage_scheduler
//
// Self-checking bench for gcn_stage_scheduler with a 16-cycle watchdog.
// Expected argmax vectors are queued when a run is launched and popped when
// the run completes; per-cycle expectations are derived from the run phase.
// -----------------------------------------------------------------------------
module tb_gcn_stage_scheduler;

    localparam int ROWS = 6;
    localparam int COLS = 2;
    localparam int FW   = $clog2(ROWS);
    localparam int TO   = 16;
    localparam int CW   = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            clear_err = 1'b0;
    logic            done_trans = 1'b0;
    logic            done_comb_in = 1'b0;
    logic            done_arg = 1'b0;
    logic            host_rd_req = 1'b0;
    logic [FW-1:0]   argmax_read_row = '0;
    logic [FW-1:0]   host_read_row = '0;
    logic [COLS-1:0] max_addi_ans [0:ROWS-1];

    logic            start_trans, start_comb, arg_go, host_rd_gnt;
    logic [FW-1:0]   mem_read_row;
    logic [COLS-1:0] result [0:ROWS-1];
    logic            result_valid, busy, error;
    logic [1:0]      err_stage;
    logic [CW-1:0]   run_cycles;

    int n_vec = 0;
    int n_err = 0;

    logic [ROWS*COLS-1:0] exp_q [$];
    logic [ROWS*COLS-1:0] last_res = '0;

    gcn_stage_scheduler #(
        .ARGMAX_ROWS     (ROWS),
        .ARGMAX_COLS     (COLS),
        .TIMEOUT_CYCLES  (TO),
        .CYCLE_CNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .clear_err       (clear_err),
        .start_trans     (start_trans),
        .done_trans      (done_trans),
        .start_comb      (start_comb),
        .done_comb_in    (done_comb_in),
        .arg_go          (arg_go),
        .done_arg        (done_arg),
        .max_addi_ans    (max_addi_ans),
        .argmax_read_row (argmax_read_row),
        .host_rd_req     (host_rd_req),
        .host_read_row   (host_read_row),
        .host_rd_gnt     (host_rd_gnt),
        .mem_read_row    (mem_read_row),
        .result          (result),
        .result_valid    (result_valid),
        .busy            (busy),
        .error           (error),
        .err_stage       (err_stage),
        .run_cycles      (run_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [ROWS*COLS-1:0] flat_result();
        logic [ROWS*COLS-1:0] f;
        for (int i = 0; i < ROWS; i++) f[i*COLS +: COLS] = result[i];
        return f;
    endfunction

    task automatic set_ans(input logic [ROWS*COLS-1:0] v);
        for (int i = 0; i < ROWS; i++) max_addi_ans[i] = v[i*COLS +: COLS];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete run: TRANS lasts nt cycles, COMB nc, ARGMAX na, each done
    // asserted in the last cycle of its stage. With inject set, start and
    // done_arg are pulsed in the first TRANS cycle and must be ignored.
    task automatic run_flow(input string name, input int nt, input int nc,
                            input int na, input logic [ROWS*COLS-1:0] vals,
                            input bit inject);
        int lens [3];
        logic [FW-1:0] exp_row;
        logic [ROWS*COLS-1:0] exp_res;
        lens = '{nt, nc, na};
        set_ans(~vals);
        exp_q.push_back(vals);
        start = 1'b1;
        step();
        start = 1'b0;
        n_vec++;
        if (flat_result() !== last_res) begin
            n_err++;
            $display("FAIL %s result_hold: got %h want %h", name, flat_result(), last_res);
        end
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < lens[p]; k++) begin
                argmax_read_row = FW'((k + p) % ROWS);
                #1;
                exp_row = (p == 2) ? argmax_read_row : '0;
                n_vec++;
                if (busy !== 1'b1 || error !== 1'b0 || result_valid !== 1'b0 ||
                    host_rd_gnt !== 1'b0 || mem_read_row !== exp_row) begin
                    n_err++;
                    $display("FAIL %s busy_state p%0d c%0d: got busy=%b err=%b valid=%b gnt=%b row=%0d want busy=1 err=0 valid=0 gnt=0 row=%0d",
                             name, p, k, busy, error, result_valid, host_rd_gnt, mem_read_row, exp_row);
                end
                n_vec++;
                if (start_trans !== (p == 0 && k == 0) || start_comb !== (p == 1 && k == 0) ||
                    arg_go !== (p == 2)) begin
                    n_err++;
                    $display("FAIL %s pulses p%0d c%0d: got st=%b sc=%b go=%b want st=%b sc=%b go=%b",
                             name, p, k, start_trans, start_comb, arg_go,
                             (p == 0 && k == 0), (p == 1 && k == 0), (p == 2));
                end
                done_trans   = (p == 0 && k == lens[0] - 1);
                done_comb_in = (p == 1 && k == lens[1] - 1);
                if (inject && p == 0 && k == 0) begin
                    start    = 1'b1;
                    done_arg = 1'b1;
                end else begin
                    start    = 1'b0;
                    done_arg = (p == 2 && k == lens[2] - 1);
                end
                if (p == 2 && k == lens[2] - 1) set_ans(vals);
                step();
            end
        end
        done_trans   = 1'b0;
        done_comb_in = 1'b0;
        done_arg     = 1'b0;
        start        = 1'b0;
        set_ans(~vals);
        #1;
        n_vec++;
        if (busy !== 1'b0 || result_valid !== 1'b1 || arg_go !== 1'b0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL %s done_state: got busy=%b valid=%b go=%b err=%b want busy=0 valid=1 go=0 err=0",
                     name, busy, result_valid, arg_go, error);
        end
        n_vec++;
        if (run_cycles !== CW'(nt + nc + na)) begin
            n_err++;
            $display("FAIL %s run_cycles: got %0d want %0d", name, run_cycles, nt + nc + na);
        end
        n_vec++;
        if (host_rd_gnt !== host_rd_req || mem_read_row !== host_read_row) begin
            n_err++;
            $display("FAIL %s idle_arb: got gnt=%b row=%0d want gnt=%b row=%0d",
                     name, host_rd_gnt, mem_read_row, host_rd_req, host_read_row);
        end
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s scoreboard: got empty queue want one entry", name);
        end else begin
            exp_res = exp_q.pop_front();
            if (flat_result() !== exp_res) begin
                n_err++;
                $display("FAIL %s result: got %h want %h", name, flat_result(), exp_res);
            end
            last_res = exp_res;
        end
    endtask

    task automatic test_reset();
        set_ans('0);
        host_rd_req   = 1'b0;
        host_read_row = FW'(5);
        #2;
        n_vec++;
        if (start_trans !== 1'b0 || start_comb !== 1'b0 || arg_go !== 1'b0 ||
            host_rd_gnt !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b0 ||
            error !== 1'b0 || err_stage !== 2'd0 || run_cycles !== '0 ||
            flat_result() !== '0 || mem_read_row !== FW'(5)) begin
            n_err++;
            $display("FAIL reset_values: got st=%b sc=%b go=%b gnt=%b valid=%b busy=%b err=%b stage=%0d cyc=%0d res=%h row=%0d want all 0 row=5",
                     start_trans, start_comb, arg_go, host_rd_gnt, result_valid, busy,
                     error, err_stage, run_cycles, flat_result(), mem_read_row);
        end
        step();
        reset = 1'b1;
        step();
        n_vec++;
        if (busy !== 1'b0 || start_trans !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got busy=%b st=%b want 0 0", busy, start_trans);
        end
    endtask

    task automatic test_min_run();
        run_flow("min_run", 1, 1, 1, 12'b10_01_00_11_10_01, 1'b0);
    endtask

    task automatic test_normal();
        // entries {1,0,2,1,0,2}, entry 0 in the low bits
        run_flow("normal", 5, 8, 12, 12'b10_00_01_10_00_01, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_flow("b2b_a", 2, 3, 2, 12'b11_11_00_00_01_10, 1'b0);
        run_flow("b2b_b", 3, 2, 4, 12'b00_01_10_11_00_01, 1'b0);
    endtask

    task automatic test_ignored();
        run_flow("ignored", 5, 2, 3, 12'b01_10_01_10_01_10, 1'b1);
    endtask

    task automatic test_timeout_race();
        run_flow("race", TO, 2, TO, 12'b10_10_01_01_00_11, 1'b0);
    endtask

    task automatic test_arbitration();
        host_rd_req   = 1'b1;
        host_read_row = FW'(4);
        #1;
        n_vec++;
        if (host_rd_gnt !== 1'b1 || mem_read_row !== FW'(4)) begin
            n_err++;
            $display("FAIL arb_idle: got gnt=%b row=%0d want gnt=1 row=4", host_rd_gnt, mem_read_row);
        end
        run_flow("arb", 2, 2, 6, 12'b00_11_10_01_11_00, 1'b0);
    endtask

    task automatic test_watchdog();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        done_trans = 1'b1;
        step();
        done_trans = 1'b0;
        for (int k = 0; k < TO; k++) begin
            n_vec++;
            if (busy !== 1'b1 || error !== 1'b0 || arg_go !== 1'b0) begin
                n_err++;
                $display("FAIL wdog_comb c%0d: got busy=%b err=%b go=%b want 1 0 0", k, busy, error, arg_go);
            end
            step();
        end
        n_vec++;
        if (error !== 1'b1 || err_stage !== 2'd2 || busy !== 1'b0 || arg_go !== 1'b0 ||
            run_cycles !== CW'(2 + TO) || result_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wdog_fire: got err=%b stage=%0d busy=%b go=%b cyc=%0d valid=%b want 1 2 0 0 %0d 0",
                     error, err_stage, busy, arg_go, run_cycles, result_valid, 2 + TO);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_vec++;
        if (error !== 1'b1 || err_stage !== 2'd2 || start_trans !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL wdog_start_ignored: got err=%b stage=%0d st=%b busy=%b want 1 2 0 0",
                     error, err_stage, start_trans, busy);
        end
        n_vec++;
        if (host_rd_gnt !== 1'b1 || mem_read_row !== FW'(4)) begin
            n_err++;
            $display("FAIL wdog_arb: got gnt=%b row=%0d want gnt=1 row=4", host_rd_gnt, mem_read_row);
        end
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        n_vec++;
        if (error !== 1'b0 || err_stage !== 2'd0 || busy !== 1'b0 || run_cycles !== CW'(2 + TO)) begin
            n_err++;
            $display("FAIL wdog_clear: got err=%b stage=%0d busy=%b cyc=%0d want 0 0 0 %0d",
                     error, err_stage, busy, run_cycles, 2 + TO);
        end
        run_flow("after_clear", 1, 1, 1, 12'b01_01_01_10_10_10, 1'b0);
    endtask

    task automatic test_reset_mid_argmax();
        start = 1'b1;
        step();
        start = 1'b0;
        done_trans = 1'b1;
        step();
        done_trans = 1'b0;
        done_comb_in = 1'b1;
        step();
        done_comb_in = 1'b0;
        step();
        n_vec++;
        if (arg_go !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_argmax: got go=%b busy=%b want 1 1", arg_go, busy);
        end
        host_rd_req   = 1'b0;
        host_read_row = '0;
        #1;
        reset = 1'b0;
        #1;
        n_vec++;
        if (start_trans !== 1'b0 || start_comb !== 1'b0 || arg_go !== 1'b0 ||
            host_rd_gnt !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b0 ||
            error !== 1'b0 || err_stage !== 2'd0 || run_cycles !== '0 ||
            flat_result() !== '0 || mem_read_row !== '0) begin
            n_err++;
            $display("FAIL async_reset: got st=%b sc=%b go=%b gnt=%b valid=%b busy=%b err=%b stage=%0d cyc=%0d res=%h row=%0d want all 0",
                     start_trans, start_comb, arg_go, host_rd_gnt, result_valid, busy,
                     error, err_stage, run_cycles, flat_result(), mem_read_row);
        end
        @(posedge clk);
        #1;
        reset    = 1'b1;
        last_res = '0;
        step();
        run_flow("post_reset", 2, 3, 4, 12'b10_00_01_10_00_01, 1'b0);
    endtask

    initial begin
        test_reset();
        test_min_run();
        test_normal();
        test_back_to_back();
        test_ignored();
        test_arbitration();
        test_timeout_race();
        test_watchdog();
        test_reset_mid_argmax();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
